// File: rtl/rom_loader.sv
// Streams bytes from a byte source into a 32-bit ROM, little-endian, with length check and abort.
// Outputs are registered; write/done/err pulses appear one cycle after the state that raises them.
module rom_loader #(
    parameter logic [31:0] BaseAddr = 32'h0000_0000,
    parameter int unsigned WordNum  = 4096
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [31:0] len_i,
    input  logic        abort_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        byte_ready_o,
    output logic        rom_we_o,
    output logic [31:0] rom_addr_o,
    output logic [31:0] rom_data_o,
    output logic        busy_o,
    output logic        cpu_hold_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] checksum_o
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRecv  = 2'd1;
    localparam logic [1:0] StWrite = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] len_q, len_d;
    logic [31:0] word_cnt_q, word_cnt_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] word_q, word_d;
    logic [31:0] addr_q, addr_d;
    logic        ready_q, ready_d;
    logic        we_q, we_d;
    logic [31:0] rom_addr_q, rom_addr_d;
    logic [31:0] rom_data_q, rom_data_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [31:0] checksum_q, checksum_d;

    logic len_ok;
    logic accept;

    assign len_ok = (len_i != 32'd0) && (len_i <= 32'(WordNum));
    assign accept = byte_valid_i && ready_q;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        addr_d     = addr_q;
        rom_addr_d = rom_addr_q;
        rom_data_d = rom_data_q;
        checksum_d = checksum_q;
        we_d       = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    if (len_ok) begin
                        state_d    = StRecv;
                        len_d      = len_i;
                        word_cnt_d = 32'd0;
                        byte_cnt_d = 2'd0;
                        addr_d     = BaseAddr;
                        checksum_d = 32'd0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StRecv: begin
                if (abort_i) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                end else if (accept) begin
                    // Shift in from the top so the first byte ends up in bits [7:0].
                    word_d     = {byte_i, word_q[31:8]};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                if (abort_i) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                end else begin
                    we_d       = 1'b1;
                    rom_addr_d = addr_q;
                    rom_data_d = word_q;
                    checksum_d = checksum_q + word_q;
                    word_cnt_d = word_cnt_q + 32'd1;
                    addr_d     = addr_q + 32'd4;
                    byte_cnt_d = 2'd0;
                    state_d    = (word_cnt_q + 32'd1 == len_q) ? StDone : StRecv;
                end
            end
            default: begin
                done_d  = 1'b1;
                state_d = StIdle;
            end
        endcase

        ready_d = (state_d == StRecv);
        // Stays high through the cycle the last write is presented, so the core never sees it.
        busy_d  = (state_d != StIdle);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            len_q      <= 32'd0;
            word_cnt_q <= 32'd0;
            byte_cnt_q <= 2'd0;
            word_q     <= 32'd0;
            addr_q     <= 32'd0;
            ready_q    <= 1'b0;
            we_q       <= 1'b0;
            rom_addr_q <= 32'd0;
            rom_data_q <= 32'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            checksum_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
            addr_q     <= addr_d;
            ready_q    <= ready_d;
            we_q       <= we_d;
            rom_addr_q <= rom_addr_d;
            rom_data_q <= rom_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            checksum_q <= checksum_d;
        end
    end

    assign byte_ready_o = ready_q;
    assign rom_we_o     = we_q;
    assign rom_addr_o   = rom_addr_q;
    assign rom_data_o   = rom_data_q;
    assign busy_o       = busy_q;
    assign cpu_hold_o   = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign checksum_o   = checksum_q;

endmodule
